// File: rtl/alu_seq_pkg.sv
// Shared types and ALU command encodings for the multi-precision ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SHL1 = 3'd1,
    OP_SHR1 = 3'd2,
    OP_XOR  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_SUB  = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SHL = 3'b001;
  localparam logic [2:0] ALU_SHR = 3'b010;
  localparam logic [2:0] ALU_NOT = 3'b111;

  // Bitwise ops leave the carry chain untouched and report cout=0.
  function automatic logic is_bitwise(op_e op);
    return op inside {OP_XOR, OP_AND, OP_OR, OP_NOT};
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit (master) and alu_seq (slave).
interface alu_seq_if #(parameter int NBYTES = 4);
  import alu_seq_pkg::*;

  logic                  start;
  op_e                   op;
  logic [8*NBYTES-1:0]   a_in;
  logic [8*NBYTES-1:0]   b_in;
  logic                  cin;
  logic                  ready;
  logic                  done;
  logic [8*NBYTES-1:0]   result_out;
  logic                  cout_out;
  logic                  zero_out;
  logic                  pari_out;

  modport master (
    output start, op, a_in, b_in, cin,
    input  ready, done, result_out, cout_out, zero_out, pari_out
  );

  modport slave (
    input  start, op, a_in, b_in, cin,
    output ready, done, result_out, cout_out, zero_out, pari_out
  );

endinterface

// File: rtl/alu_seq.sv
// Drives an external 8-bit combinational alu one byte per cycle to perform an
// NBYTES-wide operation, chaining carry/shift bits between bytes.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_if.slave    bus,
  output logic [2:0]  alu_cmd,
  output logic [7:0]  alu_accum,
  output logic [7:0]  alu_op,
  output logic        alu_cin,
  input  logic [7:0]  alu_result,
  input  logic        alu_cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  logic [1:0]    state_q,  state_d;
  logic [IW-1:0] idx_q,    idx_d;
  logic [W-1:0]  a_q,      a_d;
  logic [W-1:0]  b_q,      b_d;
  logic [W-1:0]  buf_q,    buf_d;
  logic [W-1:0]  result_q, result_d;
  op_e           op_q,     op_d;
  logic          carry_q,  carry_d;
  logic          cout_q,   cout_d;
  logic          zero_q,   zero_d;
  logic          pari_q,   pari_d;

  logic [IW-1:0] lane;
  logic [7:0]    a_byte;
  logic [7:0]    b_byte;

  // SHR1 walks MSB to LSB so the shifted-in bit enters the top byte first.
  always_comb begin
    lane   = (op_q == OP_SHR1) ? (LAST_IDX - idx_q) : idx_q;
    a_byte = a_q[{lane, 3'b000} +: 8];
    b_byte = b_q[{lane, 3'b000} +: 8];
  end

  // NOTE: every output gets a default before the case, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    alu_cmd   = 3'b000;
    alu_accum = 8'h00;
    alu_op    = 8'h00;
    alu_cin   = 1'b0;
    if (state_q == ST_RUN) begin
      alu_accum = a_byte;
      case (op_q)
        OP_ADD:  begin alu_cmd = ALU_ADD; alu_op = b_byte;  alu_cin = carry_q; end
        OP_SUB:  begin alu_cmd = ALU_ADD; alu_op = ~b_byte; alu_cin = carry_q; end
        OP_SHL1: begin alu_cmd = ALU_SHL; alu_cin = carry_q; end
        OP_SHR1: begin alu_cmd = ALU_SHR; alu_cin = carry_q; end
        OP_NOT:  begin alu_cmd = ALU_NOT; alu_op = b_byte; end
        default: begin alu_cmd = op_q;    alu_op = b_byte; end
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    buf_d    = buf_q;
    result_d = result_q;
    op_d     = op_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    pari_d   = pari_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          op_d    = bus.op;
          carry_d = (bus.op == OP_SUB) ? 1'b1 : bus.cin;
          idx_d   = '0;
          buf_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        buf_d[{lane, 3'b000} +: 8] = alu_result;
        if (!is_bitwise(op_q)) carry_d = alu_cout;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          // Publish the completed word, including the byte captured this edge.
          idx_d    = '0;
          result_d = buf_d;
          cout_d   = is_bitwise(op_q) ? 1'b0 : alu_cout;
          zero_d   = (buf_d == '0);
          pari_d   = ^buf_d;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: operand and working registers are reset too, so an aborted
  // operation leaves nothing behind; sequential state uses non-blocking <=.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      buf_q    <= '0;
      result_q <= '0;
      op_q     <= OP_ADD;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      pari_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      buf_q    <= buf_d;
      result_q <= result_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      pari_q   <= pari_d;
    end
  end

  assign bus.ready      = (state_q == ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.result_out = result_q;
  assign bus.cout_out   = cout_q;
  assign bus.zero_out   = zero_q;
  assign bus.pari_out   = pari_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (NBYTES=4) with a behavioural 8-bit ALU beside it.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] alu_cmd;
  logic [7:0] alu_accum, alu_op, alu_result;
  logic       alu_cin, alu_cout;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_res = '0;

  alu_seq_if #(.NBYTES(4)) bus ();

  alu_seq #(.NBYTES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_cmd    (alu_cmd),
    .alu_accum  (alu_accum),
    .alu_op     (alu_op),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_cout   (alu_cout)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit alu, shift amount fixed at 0.
  always_comb begin
    alu_result = 8'h00;
    alu_cout   = 1'b0;
    case (alu_cmd)
      3'd0: {alu_cout, alu_result} = {1'b0, alu_accum} + {1'b0, alu_op} + {8'h00, alu_cin};
      3'd1: begin alu_result = {alu_accum[6:0], alu_cin}; alu_cout = alu_accum[7]; end
      3'd2: begin alu_result = {alu_cin, alu_accum[7:1]}; alu_cout = alu_accum[0]; end
      3'd3: alu_result = alu_accum ^ alu_op;
      3'd4: alu_result = alu_accum & alu_op;
      3'd5: alu_result = alu_accum | alu_op;
      3'd6: {alu_cout, alu_result} = {1'b0, alu_accum} - {1'b0, alu_op};
      default: alu_result = ~alu_op;
    endcase
  end

  // Word-level reference: returns {cout, result}.
  function automatic logic [32:0] ref_op(op_e op, logic [31:0] a, logic [31:0] b, logic cin);
    case (op)
      OP_ADD:  return {1'b0, a} + {1'b0, b} + {32'h0, cin};
      OP_SUB:  return {a >= b, a - b};
      OP_SHL1: return {a[31], a[30:0], cin};
      OP_SHR1: return {a[0], cin, a[31:1]};
      OP_XOR:  return {1'b0, a ^ b};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      default: return {1'b0, ~b};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the done cycle.
  task automatic do_op(input op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, output int lat);
    logic held_bad;
    held_bad = 1'b0;
    check("ready_before_start", 64'(bus.ready), 64'(1));
    bus.op = op; bus.a_in = a; bus.b_in = b; bus.cin = cin; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 20) begin
      if (bus.result_out !== last_res || bus.ready) held_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("result_held_during_run", 64'(held_bad), 64'(0));
    check("done_latency", 64'(lat), 64'(5));
  endtask

  task automatic run_and_check(input string tag, input op_e op, input logic [31:0] a,
                               input logic [31:0] b, input logic cin,
                               input logic [31:0] exp_res, input logic exp_cout,
                               input logic exp_zero, input logic exp_pari);
    int lat;
    do_op(op, a, b, cin, lat);
    check({tag, " result"}, 64'(bus.result_out), 64'(exp_res));
    check({tag, " cout"},   64'(bus.cout_out),   64'(exp_cout));
    check({tag, " zero"},   64'(bus.zero_out),   64'(exp_zero));
    check({tag, " pari"},   64'(bus.pari_out),   64'(exp_pari));
    check({tag, " alu_quiet_in_done"}, 64'({alu_cmd, alu_accum, alu_op, alu_cin}), 64'(0));
    last_res = exp_res;
    @(negedge clk);
    check({tag, " done_one_cycle"}, 64'({bus.done, bus.ready}), 64'(2'b01));
  endtask

  typedef struct {
    op_e         op;
    logic [31:0] a, b;
    logic        cin;
    logic [31:0] res;
    logic        cout, zero, pari;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [32:0] m;
    int lat;

    vecs[0]  = '{OP_ADD,  32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{OP_SUB,  32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{OP_SUB,  32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{OP_SHL1, 32'h8000_0001, 32'h0000_0000, 1'b1, 32'h0000_0003, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{OP_SHR1, 32'h8000_0001, 32'h0000_0000, 1'b0, 32'h4000_0000, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{OP_XOR,  32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{OP_NOT,  32'h1357_9BDF, 32'h0000_00FF, 1'b1, 32'hFFFF_FF00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{OP_AND,  32'hF0F0_1234, 32'hFF00_FF00, 1'b0, 32'hF000_1200, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_OR,   32'h0000_0001, 32'h0000_0100, 1'b0, 32'h0000_0101, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{OP_SUB,  32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b1};

    bus.start = 1'b0; bus.op = OP_ADD; bus.a_in = '0; bus.b_in = '0; bus.cin = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ready_done", 64'({bus.ready, bus.done}), 64'(2'b10));
    check("reset result", 64'(bus.result_out), 64'(0));
    check("reset flags", 64'({bus.cout_out, bus.zero_out, bus.pari_out}), 64'(0));
    check("reset alu", 64'({alu_cmd, alu_accum, alu_op, alu_cin}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
                    vecs[i].res, vecs[i].cout, vecs[i].zero, vecs[i].pari);

    // start pulses in cycles 2 and 5 must be ignored and not queued.
    bus.op = OP_ADD; bus.a_in = 32'h10; bus.b_in = 32'h20; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    check("ign ready_in_run", 64'(bus.ready), 64'(0));
    bus.op = OP_SUB; bus.a_in = 32'hFFFF_FFFF; bus.b_in = 32'hFFFF_FFFF; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    check("ign no_early_done", 64'(bus.done), 64'(0));
    @(negedge clk);
    check("ign done_cycle5", 64'({bus.done, bus.ready}), 64'(2'b10));
    check("ign result", 64'(bus.result_out), 64'(32'h30));
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check("ign ready_after_done", 64'({bus.ready, bus.done}), 64'(2'b10));
    check("ign result_held", 64'(bus.result_out), 64'(32'h30));
    @(negedge clk);
    check("ign not_queued", 64'({bus.ready, bus.done}), 64'(2'b10));
    last_res = 32'h30;

    // Reset while byte 2 is on the ALU.
    bus.op = OP_ADD; bus.a_in = 32'h0101_0101; bus.b_in = 32'h0202_0202; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid byte2 accum", 64'(alu_accum), 64'(8'h01));
    rst_n = 1'b0;
    #1;
    check("mid reset ready_done", 64'({bus.ready, bus.done}), 64'(2'b10));
    check("mid reset result", 64'(bus.result_out), 64'(0));
    check("mid reset flags", 64'({bus.cout_out, bus.zero_out, bus.pari_out}), 64'(0));
    check("mid reset alu", 64'({alu_cmd, alu_accum, alu_op, alu_cin}), 64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    last_res = '0;
    run_and_check("post_reset add", OP_ADD, 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      op_e         op;
      logic [31:0] a, b;
      logic        cin;
      op  = op_e'($urandom_range(0, 7));
      a   = $urandom;
      b   = (i % 5 == 0) ? a : $urandom;
      cin = 1'($urandom_range(0, 1));
      m   = ref_op(op, a, b, cin);
      run_and_check($sformatf("rand%0d op%0d", i, op), op, a, b, cin,
                    m[31:0], m[32], (m[31:0] == 32'h0), ^m[31:0]);
    end

    do_op(OP_ADD, 32'd7, 32'd8, 1'b0, lat);
    check("final add", 64'(bus.result_out), 64'(32'd15));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
